// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder: one decimal digit per clock, LSD first, start/busy/done handshake.
// Optional invalid-digit detection is built when BCD_SERIAL_ERR_EN is defined.
module bcd_serial_adder #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  cin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  err
);

  localparam int unsigned W    = 4 * DIGITS;
  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {StIdle, StAdd, StDone} state_e;

  state_e          state_q;
  logic [W-1:0]    a_q, b_q, work_q, work_d;
  logic            carry_q, carry_d;
  logic [IdxW-1:0] idx_q;
  logic [3:0]      a_dig, b_dig, dig;
  logic [4:0]      t, t_adj;
  logic            last;
  logic            accept;

  always_comb begin
    a_dig = a_q[4*idx_q +: 4];
    b_dig = b_q[4*idx_q +: 4];
    t     = 5'(a_dig) + 5'(b_dig) + 5'(carry_q);
    t_adj = t + 5'd6;
    if (t > 5'd9) begin
      dig     = t_adj[3:0];
      carry_d = 1'b1;
    end else begin
      dig     = t[3:0];
      carry_d = 1'b0;
    end
    work_d = work_q;
    work_d[4*idx_q +: 4] = dig;
    last = (idx_q == IdxW'(DIGITS - 1));
  end

  // The done cycle doubles as the idle boundary, so back-to-back starts run every DIGITS+1 cycles.
  assign accept = start && ((state_q == StIdle) || (state_q == StDone));

`ifdef BCD_SERIAL_ERR_EN
  logic err_work_q, err_q, dig_bad;
  assign dig_bad = (a_dig > 4'd9) || (b_dig > 4'd9);
  assign err     = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      work_q  <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
`ifdef BCD_SERIAL_ERR_EN
      err_work_q <= 1'b0;
      err_q      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state_q)
        StIdle, StDone: begin
          if (accept) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            work_q  <= '0;
            idx_q   <= '0;
            busy    <= 1'b1;
            state_q <= StAdd;
`ifdef BCD_SERIAL_ERR_EN
            err_work_q <= 1'b0;
`endif
          end else begin
            state_q <= StIdle;
          end
        end
        StAdd: begin
          work_q  <= work_d;
          carry_q <= carry_d;
          idx_q   <= idx_q + IdxW'(1);
`ifdef BCD_SERIAL_ERR_EN
          err_work_q <= err_work_q | dig_bad;
`endif
          if (last) begin
            state_q <= StDone;
            idx_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b1;
            sum     <= work_d;
            cout    <= carry_d;
`ifdef BCD_SERIAL_ERR_EN
            err_q <= err_work_q | dig_bad;
`endif
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
